word_narrow_8: RTL

Narrowing serializer that converts 32-bit words into an 8-bit byte stream; it performs the inverse of the 8-to-32 zero-extension path. Words arrive over a valid/ready handshake from the command/datapath side. They leave least-significant byte first over a second valid/ready handshake toward byte-wide consumers such as the CLI output path. When compression is compiled in, a word whose upper 24 bits are zero is sent as a single byte, and that byte is flagged as zero-extendable.

---
 rtl/word_narrow_8.sv | 136 +++++++++++++
 1 files changed

// File: rtl/word_narrow_8.sv
// word_narrow_8
//   Serializes 32-bit words into an 8-bit byte stream. Words are accepted on
//   an in_valid/in_ready handshake and emitted one byte per out_valid/out_ready
//   handshake, LSB first (MSB_FIRST = 0) or MSB first (MSB_FIRST = 1).
//
//   Optional feature, selected by the NARROW_COMPRESS_EN macro:
//     defined   - a word whose bits [31:8] are zero is sent as a single byte
//                 (its bits [7:0]) with out_zx = 1, and zx_count counts them.
//     undefined - every word is sent as 4 bytes; out_zx and zx_count stay 0.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   in_word is presented
//   in_ready   word is accepted this cycle (combinational)
//   in_word    32-bit word to narrow
//   out_valid  out_byte is presented
//   out_ready  consumer accepts out_byte this cycle
//   out_byte   current byte
//   out_last   current byte is the final byte of its word
//   out_zx     word was sent compressed; consumer zero-extends out_byte
//   zx_count   saturating count of compressed words sent
module word_narrow_8 #(
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        out_last,
  output logic        out_zx,
  output logic [15:0] zx_count
);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t      state, state_n;
  logic [31:0] hold, hold_n;
  logic [1:0]  idx, idx_n;
  logic        zx, zx_n;
  logic [15:0] zx_count_n;
  logic        out_valid_n;
  logic [7:0]  out_byte_n;
  logic        out_last_n;
  logic        out_zx_n;
  logic        xfer;
  logic        accept;
  logic        zx_in;

  // Byte lane for index i; a compressed word always presents bits [7:0].
  function automatic logic [7:0] sel_byte(input logic [31:0] w,
                                          input logic [1:0]  i,
                                          input logic        z);
    logic [1:0] lane;
    lane = (MSB_FIRST != 0) ? ~i : i;
    if (z) return w[7:0];
    return w[{lane, 3'b000} +: 8];
  endfunction

  assign xfer     = out_valid && out_ready;
  assign in_ready = !reset && (state == IDLE || (xfer && out_last));
  assign accept   = in_valid && in_ready;

`ifdef NARROW_COMPRESS_EN
  assign zx_in = (in_word[31:8] == 24'h0);
`else
  assign zx_in = 1'b0;
`endif

  // The output registers are loaded from the next-state values so every
  // output except in_ready comes straight from a flop; a stall leaves the
  // next state equal to the current one, which holds the outputs stable.
  always_comb begin
    state_n    = state;
    hold_n     = hold;
    idx_n      = idx;
    zx_n       = zx;
    zx_count_n = zx_count;

    if (xfer) begin
      if (out_last) begin
        state_n = IDLE;
`ifdef NARROW_COMPRESS_EN
        if (zx && zx_count != '1) zx_count_n = zx_count + 16'd1;
`endif
      end else begin
        idx_n = idx + 2'd1;
      end
    end

    // Acceptance overrides the return to IDLE so back-to-back words flow.
    if (accept) begin
      hold_n  = in_word;
      zx_n    = zx_in;
      idx_n   = '0;
      state_n = SEND;
    end

    out_valid_n = (state_n == SEND);
    out_byte_n  = sel_byte(hold_n, idx_n, zx_n);
    out_last_n  = zx_n || (idx_n == 2'd3);
    out_zx_n    = zx_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      hold      <= '0;
      idx       <= '0;
      zx        <= 1'b0;
      zx_count  <= '0;
      out_valid <= 1'b0;
      out_byte  <= '0;
      out_last  <= 1'b0;
      out_zx    <= 1'b0;
    end else begin
      state     <= state_n;
      hold      <= hold_n;
      idx       <= idx_n;
      zx        <= zx_n;
      zx_count  <= zx_count_n;
      out_valid <= out_valid_n;
      out_byte  <= out_byte_n;
      out_last  <= out_last_n;
      out_zx    <= out_zx_n;
    end
  end

endmodule
